// File: rtl/packet_source.sv
// packet_source: traffic generator for a router injection port.
// Builds head + payload packets, tracks per-VC credits returned on flow_ctrl,
// and stamps each tail flit with the packet count and the source address.
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   enable          permits new packet starts (an in-flight packet always completes)
//   router_address  own address, placed in the tail flit
//   dest_address    destination, placed in the head flit at packet start
//   flow_ctrl       credit return {valid, vc_idx}
//   channel         {link_active (optional), flit_valid, vc_idx, head, data}
//   packet_count    tail flits sent since reset
//   error           sticky credit-overflow flag
module packet_source #(
    parameter int initial_seed           = 0,
    parameter int injection_rate         = 10000,
    parameter int buffer_size            = 64,
    parameter int num_vcs                = 8,
    parameter int max_payload_length     = 4,
    parameter int min_payload_length     = 1,
    parameter int num_dimensions         = 2,
    parameter int num_routers            = 16,
    parameter int packet_count_reg_width = 32,
    parameter int flit_data_width        = 64,
    parameter int enable_link_pm         = 1,
    localparam int vc_idx_width      = num_vcs > 1 ? $clog2(num_vcs) : 1,
    localparam int dim_addr_width    = ($clog2(num_routers) + num_dimensions - 1) / num_dimensions,
    localparam int router_addr_width = dim_addr_width * num_dimensions,
    localparam int channel_width     = (enable_link_pm != 0 ? 1 : 0) + 2 + vc_idx_width + flit_data_width
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [router_addr_width-1:0]      router_address,
    input  logic [router_addr_width-1:0]      dest_address,
    input  logic [vc_idx_width:0]             flow_ctrl,
    output logic [channel_width-1:0]          channel,
    output logic [packet_count_reg_width-1:0] packet_count,
    output logic                              error
);
    localparam int vw  = vc_idx_width;
    localparam int raw = router_addr_width;
    localparam int fdw = flit_data_width;
    localparam int pcw = packet_count_reg_width;
    localparam int cpv = buffer_size / num_vcs;
    localparam int cw  = $clog2(cpv + 1);
    localparam int lw  = $clog2(max_payload_length + 1);
    localparam int plw = max_payload_length > min_payload_length ?
                         $clog2(max_payload_length - min_payload_length + 1) : 1;
    localparam logic [cw-1:0] cred_full = cw'(cpv);
    localparam logic [lw-1:0] len_min   = lw'(min_payload_length);
    localparam logic [lw-1:0] len_max   = lw'(max_payload_length);
    // xorshift cannot leave an all-zero state, so a zero seed is replaced
    localparam logic [31:0] seed0 = initial_seed == 0 ? 32'h2545_f491 : 32'(initial_seed);

    typedef enum logic {IDLE, PAYLOAD} state_t;

    state_t state, state_d;
    logic [cw-1:0] credit [num_vcs];
    logic [vw-1:0] rr_ptr, cur_vc, sel_vc, vc_d;
    logic [lw-1:0] next_len, cur_len, idx;
    logic [31:0] rng, rng_a, rng_b, rng_d;
    logic [fdw-1:0] data_d;
    logic [channel_width-1:0] ch_d;
    logic sel_ok, roll, start, tail, valid_d, head_d, link_d;
    logic fc_valid;
    logic [vw-1:0] fc_vc;

    assign fc_valid = flow_ctrl[vw];
    assign fc_vc    = flow_ctrl[vw-1:0];

    // injection roll: uniform draw in 0..9999 compared against the rate
    assign rng_a = rng ^ (rng << 13);
    assign rng_b = rng_a ^ (rng_a >> 17);
    assign rng_d = rng_b ^ (rng_b << 5);
    assign roll  = (rng % 32'd10000) < 32'(injection_rate);

    // round-robin search; descending loop so the smallest offset from rr_ptr wins
    always_comb begin
        sel_ok = 1'b0;
        sel_vc = rr_ptr;
        for (int i = num_vcs - 1; i >= 0; i--) begin
            if (credit[(int'(rr_ptr) + i) % num_vcs] != '0) begin
                sel_ok = 1'b1;
                sel_vc = vw'((int'(rr_ptr) + i) % num_vcs);
            end
        end
    end

    always_comb begin
        state_d = state;
        valid_d = 1'b0;
        head_d  = 1'b0;
        vc_d    = '0;
        data_d  = '0;
        start   = 1'b0;
        tail    = 1'b0;
        if (state == IDLE) begin
            start = enable && roll && sel_ok;
            if (start) begin
                state_d               = PAYLOAD;
                valid_d               = 1'b1;
                head_d                = 1'b1;
                vc_d                  = sel_vc;
                data_d[plw-1:0]       = plw'(next_len - len_min);
                data_d[plw +: raw]    = dest_address;
            end
        end else if (credit[cur_vc] != '0) begin
            valid_d = 1'b1;
            vc_d    = cur_vc;
            tail    = idx + lw'(1) == cur_len;
            if (tail) begin
                state_d                    = IDLE;
                data_d[fdw-raw-pcw +: pcw] = packet_count;
                data_d[fdw-raw +: raw]     = router_address;
            end
        end
        link_d = valid_d || state == PAYLOAD;
    end

    if (enable_link_pm != 0) begin : g_pm
        assign ch_d = {link_d, valid_d, vc_d, head_d, data_d};
    end else begin : g_nopm
        assign ch_d = {valid_d, vc_d, head_d, data_d};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            channel      <= '0;
            packet_count <= '0;
            error        <= 1'b0;
            rr_ptr       <= '0;
            next_len     <= len_min;
            cur_vc       <= '0;
            cur_len      <= len_min;
            idx          <= '0;
            rng          <= seed0;
            for (int v = 0; v < num_vcs; v++) credit[v] <= cred_full;
        end else begin
            state   <= state_d;
            channel <= ch_d;
            rng     <= rng_d;
            if (start) begin
                cur_vc   <= sel_vc;
                cur_len  <= next_len;
                idx      <= '0;
                rr_ptr   <= sel_vc == vw'(num_vcs - 1) ? '0 : sel_vc + 1'b1;
                next_len <= next_len == len_max ? len_min : next_len + 1'b1;
            end
            if (valid_d && !head_d) idx <= idx + 1'b1;
            if (tail) packet_count <= packet_count + 1'b1;
            // a return and a send on the same VC cancel; a return to a full VC saturates
            for (int v = 0; v < num_vcs; v++) begin
                if (fc_valid && fc_vc == vw'(v) && !(valid_d && vc_d == vw'(v))) begin
                    if (credit[v] == cred_full) error <= 1'b1;
                    else credit[v] <= credit[v] + 1'b1;
                end else if (valid_d && vc_d == vw'(v) && !(fc_valid && fc_vc == vw'(v))) begin
                    credit[v] <= credit[v] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_packet_source.sv
// tb_packet_source: directed scoreboard bench for packet_source.
module tb_packet_source;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  router_address;
    logic [3:0]  dest;
    logic [3:0]  flow_ctrl;
    logic [69:0] channel;
    logic [31:0] packet_count;
    logic        error;

    logic [3:0]  man_fc;
    logic [3:0]  lb_fc;
    logic        loop_en;
    int          tests_run;
    int          tests_failed;
    int          flits_seen;

    logic [67:0] sb[$];
    int          m_cred[8];
    int          m_rr, m_nl, m_cnt;

    assign flow_ctrl      = loop_en ? lb_fc : man_fc;
    assign router_address = 4'h5;

    packet_source dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .router_address(router_address),
        .dest_address(dest),
        .flow_ctrl(flow_ctrl),
        .channel(channel),
        .packet_count(packet_count),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [67:0] fl(input int vc, input bit head, input logic [63:0] d);
        return {3'(vc), head, d};
    endfunction

    task automatic model_reset();
        foreach (m_cred[i]) m_cred[i] = 8;
        m_rr  = 0;
        m_nl  = 1;
        m_cnt = 0;
        sb.delete();
    endtask

    // transaction-level model: queues the flits of npk packets; with lim set it
    // honours the credits the model holds and stops where the DUT would stall
    task automatic gen(input int npk, input bit lim);
        for (int p = 0; p < npk; p++) begin
            int v;
            int len;
            v = -1;
            for (int i = 0; i < 8; i++) begin
                int c;
                c = (m_rr + i) % 8;
                if (v < 0 && (!lim || m_cred[c] > 0)) v = c;
            end
            if (v < 0) return;
            len = m_nl;
            sb.push_back(fl(v, 1'b1, {58'd0, dest, 2'(len - 1)}));
            m_cred[v]--;
            m_rr = (v + 1) % 8;
            m_nl = m_nl == 4 ? 1 : m_nl + 1;
            for (int k = 1; k <= len; k++) begin
                if (lim && m_cred[v] == 0) return;
                sb.push_back(fl(v, 1'b0, k == len ? {4'h5, m_cnt[31:0], 28'd0} : 64'd0));
                m_cred[v]--;
            end
            m_cnt++;
        end
    endtask

    task automatic do_reset(input bit lb, input logic [3:0] d);
        reset   = 1'b0;
        enable  = 1'b0;
        man_fc  = 4'd0;
        loop_en = lb;
        dest    = d;
        repeat (2) @(negedge clk);
        model_reset();
    endtask

    // output monitor: pops the scoreboard and loops credits back when enabled
    always @(posedge clk) begin
        #1;
        lb_fc = 4'd0;
        if (channel[68] === 1'b1) begin
            flits_seen++;
            lb_fc = {1'b1, channel[67:65]};
            if (sb.size() == 0) chk("unexpected_flit", channel, 'x);
            else chk("flit", {2'b00, channel[67:0]}, {2'b00, sb.pop_front()});
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        flits_seen   = 0;
        lb_fc        = 4'd0;

        // reset state, then run with no credit return until a VC runs dry
        do_reset(1'b0, 4'hA);
        chk("reset_channel", channel, 70'd0);
        chk("reset_count", packet_count, 70'd0);
        chk("reset_error", error, 70'd0);
        gen(20, 1'b1);
        enable = 1'b1;
        reset  = 1'b1;
        @(negedge clk);
        chk("first_head", {channel[68:64], channel[1:0]}, {5'b10001, 2'b00});
        repeat (49) @(negedge clk);
        chk("stall_sb_empty", sb.size(), 70'd0);
        chk("stall_count", packet_count, m_cnt);
        chk("stall_valid", channel[68], 70'd0);
        chk("stall_link", channel[69], 70'd1);

        // stalled VC3 packet resumes two cycles after a credit; enable low lets it finish
        enable = 1'b0;
        sb.push_back(fl(3, 1'b0, 64'd0));
        sb.push_back(fl(3, 1'b0, {4'h5, m_cnt[31:0], 28'd0}));
        man_fc = {1'b1, 3'd3};
        @(negedge clk);
        man_fc = 4'd0;
        chk("stall_hold", channel[68], 70'd0);
        @(negedge clk);
        chk("resume_2cyc", channel[68:65], {1'b1, 3'd3});
        man_fc = {1'b1, 3'd3};
        @(negedge clk);
        man_fc = 4'd0;
        repeat (10) @(negedge clk);
        chk("drain_count", packet_count, m_cnt + 1);
        chk("drain_idle", channel[69:68], 70'd0);
        chk("drain_sb", sb.size(), 70'd0);

        // length sequence 1,2,3,4,1 back-to-back with credits looped back
        do_reset(1'b1, 4'h3);
        gen(5, 1'b0);
        enable     = 1'b1;
        reset      = 1'b1;
        flits_seen = 0;
        repeat (15) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("b2b_flits", flits_seen, 70'd16);
        repeat (20) @(negedge clk);
        chk("len_count", packet_count, 70'd5);
        chk("len_sb", sb.size(), 70'd0);
        chk("len_error", error, 70'd0);

        // overflow on a full VC is sticky until reset
        do_reset(1'b0, 4'h6);
        reset = 1'b1;
        @(negedge clk);
        chk("err_clear", error, 70'd0);
        man_fc = {1'b1, 3'd2};
        @(negedge clk);
        man_fc = 4'd0;
        chk("err_set", error, 70'd1);
        repeat (5) @(negedge clk);
        chk("err_sticky", error, 70'd1);
        do_reset(1'b0, 4'h6);
        chk("err_reset", error, 70'd0);

        // return to VC0 in the cycle its head is sent: credit stays at 8
        gen(1, 1'b0);
        reset  = 1'b1;
        enable = 1'b1;
        man_fc = {1'b1, 3'd0};
        @(negedge clk);
        enable = 1'b0;
        man_fc = 4'd0;
        chk("samecyc_noerr", error, 70'd0);
        repeat (5) @(negedge clk);
        chk("samecyc_count", packet_count, 70'd1);
        man_fc = {1'b1, 3'd0};
        @(negedge clk);
        man_fc = 4'd0;
        chk("ret1_noerr", error, 70'd0);
        man_fc = {1'b1, 3'd0};
        @(negedge clk);
        man_fc = 4'd0;
        chk("ret2_err", error, 70'd1);

        // reset in the middle of a packet
        do_reset(1'b1, 4'h9);
        gen(4, 1'b0);
        reset  = 1'b1;
        enable = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_link", channel[69], 70'd1);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        chk("mid_rst_channel", channel, 70'd0);
        chk("mid_rst_count", packet_count, 70'd0);
        @(negedge clk);
        gen(1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk("restart_head", {channel[68:64], channel[1:0]}, {5'b10001, 2'b00});
        repeat (5) @(negedge clk);
        chk("restart_count", packet_count, 70'd1);
        chk("restart_sb", sb.size(), 70'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
